// File: rtl/keyboard_encoder.sv
// ASCII to PS/2 set-2 scan-code encoder: make / F0 / break bytes on a valid/ready
// byte stream, with left-shift wrapping for uppercase letters.
module keyboard_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       err,
  output logic       busy,
  output logic [7:0] key_cnt
);

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SHIFT_CODE = 8'h12;
  localparam logic [BYTE_W-1:0] BREAK_CODE = 8'hF0;

  typedef enum logic [2:0] {
    IDLE, SH_MK, KEY_MK, KEY_BRKP, KEY_BRK, SH_BRKP, SH_BRK
  } state_t;

  state_t            state;
  logic [BYTE_W-1:0] code;
  logic              upper;

  logic              in_upper_c;
  logic [BYTE_W-1:0] in_lower_c;
  logic [BYTE_W-1:0] in_code_c;
  logic              xfer_c;

  // Scan code for a lowercase letter or digit; 00 marks an unmapped character.
  function automatic logic [BYTE_W-1:0] lookup(input logic [BYTE_W-1:0] c);
    case (c)
      8'h30: lookup = 8'h45;  8'h31: lookup = 8'h16;  8'h32: lookup = 8'h1E;
      8'h33: lookup = 8'h26;  8'h34: lookup = 8'h25;  8'h35: lookup = 8'h2E;
      8'h36: lookup = 8'h36;  8'h37: lookup = 8'h3D;  8'h38: lookup = 8'h3E;
      8'h39: lookup = 8'h46;
      8'h61: lookup = 8'h1C;  8'h62: lookup = 8'h32;  8'h63: lookup = 8'h21;
      8'h64: lookup = 8'h23;  8'h65: lookup = 8'h24;  8'h66: lookup = 8'h2B;
      8'h67: lookup = 8'h34;  8'h68: lookup = 8'h33;  8'h69: lookup = 8'h43;
      8'h6A: lookup = 8'h3B;  8'h6B: lookup = 8'h42;  8'h6C: lookup = 8'h4B;
      8'h6D: lookup = 8'h3A;  8'h6E: lookup = 8'h31;  8'h6F: lookup = 8'h44;
      8'h70: lookup = 8'h4D;  8'h71: lookup = 8'h15;  8'h72: lookup = 8'h2D;
      8'h73: lookup = 8'h1B;  8'h74: lookup = 8'h2C;  8'h75: lookup = 8'h3C;
      8'h76: lookup = 8'h2A;  8'h77: lookup = 8'h1D;  8'h78: lookup = 8'h22;
      8'h79: lookup = 8'h35;  8'h7A: lookup = 8'h1A;
      default: lookup = 8'h00;
    endcase
  endfunction

  always_comb begin
    in_upper_c = (in_data >= 8'h41) && (in_data <= 8'h5A);
    in_lower_c = in_upper_c ? (in_data | 8'h20) : in_data;
    in_code_c  = lookup(in_lower_c);
    xfer_c     = out_valid && out_ready;
  end

  // Sequencer: state names the byte currently presented on out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      code      <= '0;
      upper     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      key_cnt   <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (in_code_c != 8'h00) begin
              code      <= in_code_c;
              upper     <= in_upper_c;
              state     <= in_upper_c ? SH_MK : KEY_MK;
              out_data  <= in_upper_c ? SHIFT_CODE : in_code_c;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              busy      <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SH_MK: if (xfer_c) begin
          state    <= KEY_MK;
          out_data <= code;
        end
        KEY_MK: if (xfer_c) begin
          state    <= KEY_BRKP;
          out_data <= BREAK_CODE;
        end
        KEY_BRKP: if (xfer_c) begin
          state    <= KEY_BRK;
          out_data <= code;
        end
        KEY_BRK: if (xfer_c) begin
          if (upper) begin
            state    <= SH_BRKP;
            out_data <= BREAK_CODE;
          end else begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            key_cnt   <= key_cnt + 8'd1;
          end
        end
        SH_BRKP: if (xfer_c) begin
          state    <= SH_BRK;
          out_data <= SHIFT_CODE;
        end
        SH_BRK: if (xfer_c) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          key_cnt   <= key_cnt + 8'd1;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keyboard_encoder.sv
// Scoreboard bench for keyboard_encoder: expected bytes queued at issue, popped by a
// monitor on each transfer, and the stream decoded back to ASCII.
module tb_keyboard_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       err;
  logic       busy;
  logic [7:0] key_cnt;

  keyboard_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err), .busy(busy), .key_cnt(key_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] dig_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                               8'h3E, 8'h46};
  logic [7:0] let_tab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                               8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                               8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                               8'h35, 8'h1A};

  logic [7:0] sb [$];
  logic [7:0] sent_q [$];
  int         checks = 0;
  int         errors = 0;
  int         mode = 0;
  logic [7:0] exp_cnt = 8'h00;
  logic       dec_shift = 1'b0;
  logic       dec_brk = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference encoding: {supported, code}, with uppercase reported separately.
  function automatic logic [8:0] ref_code(input logic [7:0] c);
    int v = int'(c);
    if (v >= 48 && v <= 57) return {1'b1, dig_tab[v - 48]};
    if (v >= 97 && v <= 122) return {1'b1, let_tab[v - 97]};
    if (v >= 65 && v <= 90) return {1'b1, let_tab[v - 65]};
    return 9'h000;
  endfunction

  function automatic logic [7:0] ref_ascii(input logic [7:0] code, input logic shift);
    for (int i = 0; i < 10; i++) if (dig_tab[i] == code) return 8'(48 + i);
    for (int i = 0; i < 26; i++) if (let_tab[i] == code) return 8'((shift ? 65 : 97) + i);
    return 8'h00;
  endfunction

  // Keyboard-side decoder: emits a character on each key make code.
  task automatic decode(input logic [7:0] b);
    logic [7:0] want;
    if (b == 8'hF0) dec_brk = 1'b1;
    else if (dec_brk) begin
      dec_brk = 1'b0;
      if (b == 8'h12) dec_shift = 1'b0;
    end else if (b == 8'h12) dec_shift = 1'b1;
    else begin
      want = (sent_q.size() > 0) ? sent_q.pop_front() : 8'h00;
      check("roundtrip_ascii", 32'(ref_ascii(b, dec_shift)), 32'(want));
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_byte", 32'(out_data), 32'h100);
        end else begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e));
        end
        decode(out_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = !out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] c);
    int t = 0;
    logic [8:0] r;
    in_valid = 1'b1;
    in_data  = c;
    while (!in_ready && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    r = ref_code(c);
    if (r[8]) begin
      if (c >= 8'h41 && c <= 8'h5A)
        sb = {sb, 8'h12, r[7:0], 8'hF0, r[7:0], 8'hF0, 8'h12};
      else
        sb = {sb, r[7:0], 8'hF0, r[7:0]};
      sent_q.push_back(c);
      exp_cnt = exp_cnt + 8'd1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!r[8]) begin
      check("err_pulse", 32'(err), 32'd1);
      check("unsup_ready", 32'(in_ready), 32'd1);
      check("unsup_no_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("err_clear", 32'(err), 32'd0);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!(in_ready && sb.size() == 0) && t < 400);
    check("idle_reached", 32'(in_ready && sb.size() == 0), 32'd1);
    check("key_cnt", 32'(key_cnt), 32'(exp_cnt));
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    sb.delete();
    sent_q.delete();
    exp_cnt   = 8'h00;
    dec_shift = 1'b0;
    dec_brk   = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_key_cnt", 32'(key_cnt), 32'd0);
  endtask

  initial begin
    int t;
    int k;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    fork
      monitor();
      ready_drv();
    join_none
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // 'a' with out_ready high: in_ready back exactly 4 cycles after accept
    send(8'h61);
    repeat (2) @(posedge clk);
    #1;
    check("a_ready_low_n3", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("a_ready_high_n4", 32'(in_ready), 32'd1);
    wait_idle();

    mode = 1;
    send(8'h5A);
    wait_idle();
    mode = 0;
    @(posedge clk);
    #1;

    send(8'h23);
    send(8'h35);
    wait_idle();

    // reset after the second byte of 'Q'
    send(8'h51);
    t = 0;
    while (sb.size() > 4 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_values();
    flush_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h71);
    wait_idle();

    // randomized mix with random backpressure
    mode = 2;
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 3));
      case (k)
        0: send(8'(97 + $urandom_range(0, 25)));
        1: send(8'(65 + $urandom_range(0, 25)));
        2: send(8'(48 + $urandom_range(0, 9)));
        default: send(8'($urandom_range(0, 255)));
      endcase
    end
    wait_idle();
    mode = 0;

    // 256 keystrokes from reset wrap key_cnt to 00
    rst = 1'b1;
    @(posedge clk);
    #1;
    flush_model();
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) send(8'(97 + $urandom_range(0, 25)));
    wait_idle();
    check("wrap_key_cnt", 32'(key_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keyboard_encoder.md
# keyboard_encoder

Converts ASCII characters into PS/2 set-2 scan-code byte sequences (make, break prefix, break), wrapping uppercase letters in left-shift make/break. It is the transmit-side counterpart of the keyboard decoder: it drives a scan-code byte stream into the decoder or a PS/2 transmitter, for keyboard emulation and self-test. Input and output are valid/ready byte streams.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ASCII byte offered
- in_ready  out  1  encoder can accept a character; high only in IDLE
- in_data  in  8  ASCII character
- out_valid  out  1  scan-code byte available
- out_ready  in  1  downstream accepts the byte
- out_data  out  8  scan-code byte
- err  out  1  one-cycle pulse: accepted character has no mapping
- busy  out  1  high while a sequence is in progress (state != IDLE)
- key_cnt  out  8  completed keystroke sequences, wraps 255->0

## Operation
- Supported characters:
  - '0'-'9' map to 45,16,1E,26,25,2E,36,3D,3E,46.
  - 'a'-'z' map to 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A.
  - 'A'-'Z' use the same code as the matching lowercase letter with the shift wrap.
- Lowercase or digit emits 3 bytes: code, F0, code.
- Uppercase emits 6 bytes: 12, code, F0, code, F0, 12.
- Any other in_data is an unsupported character:
  - Still accepted (in_valid & in_ready).
  - Emits no bytes; err pulses the next cycle; state stays IDLE.
- States:
  - IDLE -> SH_MK (upper) or KEY_MK (lower/digit) on a supported accept.
  - SH_MK -> KEY_MK -> KEY_BRKP -> KEY_BRK.
  - KEY_BRK -> IDLE (lower/digit) or SH_BRKP (upper).
  - SH_BRKP -> SH_BRK -> IDLE.
- Non-IDLE state advances only on a transfer (out_valid & out_ready).
- Code byte and the uppercase flag are latched on accept; in_data is ignored afterwards.
- out_data / out_valid:
  - Registered.
  - Must hold stable while out_valid & !out_ready.
  - out_valid never drops without a transfer.
- key_cnt increments by 1 on transfer of the final byte of a sequence (KEY_BRK for lower/digit, SH_BRK for upper). Unsupported characters do not count.
- Reset values:
  - in_ready=1, out_valid=0, out_data=00, err=0, busy=0, key_cnt=00, state IDLE.
  - Reset mid-sequence abandons the sequence; no resumption after release.

## Timing
- Accept at edge N -> first byte valid from cycle N+1.
- With out_ready held high, one byte transfers per cycle.
- Lowercase: bytes at N+1..N+3; in_ready high again at N+4.
- Uppercase: bytes at N+1..N+6; in_ready high at N+7.
- Back-to-back with out_ready high: one character every 4 (lower) or 7 (upper) cycles.
- Final-byte transfer at edge M: state IDLE, in_ready=1, out_valid=0, and key_cnt updated, all visible in cycle M+1. No combinational in_valid->in_ready path.
- Unsupported accept at N: err=1 in cycle N+1 only; in_ready stays 1, so a new character may be accepted at N+1.
- out_ready low stalls indefinitely with no byte lost or duplicated. out_ready is sampled only while out_valid=1.
- in_valid while busy is ignored; the source must hold the character until in_ready.

## Test plan
- Reset, then idle: in_ready=1, out_valid=0, key_cnt=00, err=0.
- 'a' (61) with out_ready=1 -> 1C, F0, 1C on consecutive cycles; key_cnt=01; in_ready returns 4 cycles after accept.
- 'Z' (5A) with out_ready toggling 1,0,1,0 -> 12, 1A, F0, 1A, F0, 12 each exactly once; out_data stable during stalls; key_cnt +1.
- '#' (23) -> err one-cycle pulse, no out_valid, key_cnt unchanged; a following '5' (35) -> 2E, F0, 2E.
- Assert rst after the second byte of 'Q' -> outputs at reset values immediately; after release, 'q' yields 15, F0, 15 cleanly.
- 256 lowercase characters with out_ready=1 -> key_cnt wraps to 00; the byte stream round-trips through the keyboard decoder to the same ASCII.
